// File: rtl/vta_mem_dpi_responder.sv
// vta_mem_dpi_responder
//   Memory responder for the VTA DPI memory-request protocol. It accepts
//   read/write bursts from an initiator and serves them from an internal word
//   array, so benches can run without a host-side C memory model.
//
// Ports
//   clock, reset        rising-edge clock, asynchronous active-high reset
//   dpi_req_valid       1-cycle request strobe
//   dpi_req_opcode      0 = read, 1 = write
//   dpi_req_len         burst length minus one
//   dpi_req_addr        byte start address; byte-offset bits are ignored
//   dpi_wr_valid/bits   write beat (no backpressure)
//   dpi_rd_valid/bits   registered read beat
//   dpi_rd_ready        initiator accepts the current read beat
//   busy                high while a burst is in progress
//   err                 sticky protocol-violation flag, cleared only by reset
module vta_mem_dpi_responder #(
  parameter int LEN_BITS  = 8,
  parameter int ADDR_BITS = 64,
  parameter int DATA_BITS = 64,
  parameter int MEM_WORDS = 4096
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 dpi_req_valid,
  input  logic                 dpi_req_opcode,
  input  logic [LEN_BITS-1:0]  dpi_req_len,
  input  logic [ADDR_BITS-1:0] dpi_req_addr,
  input  logic                 dpi_wr_valid,
  input  logic [DATA_BITS-1:0] dpi_wr_bits,
  output logic                 dpi_rd_valid,
  output logic [DATA_BITS-1:0] dpi_rd_bits,
  input  logic                 dpi_rd_ready,
  output logic                 busy,
  output logic                 err
);

  localparam int OFF_BITS = $clog2(DATA_BITS / 8);
  localparam int IDX_BITS = $clog2(MEM_WORDS);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE} state_t;

  state_t               r_state;
  logic [IDX_BITS-1:0]  r_idx;        // word index of the current beat
  logic [LEN_BITS-1:0]  r_rem;        // beats left after the current one
  logic                 r_rd_valid;
  logic [DATA_BITS-1:0] r_rd_bits;
  logic                 r_busy;
  logic                 r_err;

  logic [DATA_BITS-1:0] r_mem [MEM_WORDS];

  logic [IDX_BITS-1:0]  w_req_idx;
  logic [IDX_BITS-1:0]  w_idx_inc;
  logic [IDX_BITS-1:0]  w_rd_addr;
  logic [DATA_BITS-1:0] w_rd_data;
  logic                 w_hs;
  logic                 w_last;
  logic                 w_mem_we;
  logic                 w_viol;
  logic                 w_unused_addr;

  // Slicing above the byte offset both drops the offset and wraps modulo
  // MEM_WORDS; the remaining address bits are intentionally ignored.
  assign w_req_idx     = dpi_req_addr[OFF_BITS +: IDX_BITS];
  assign w_unused_addr = ^dpi_req_addr;
  assign w_idx_inc     = r_idx + 1'b1;

  // One array read port: the request index in IDLE (first beat), otherwise
  // the following beat so it is ready at the handshake edge.
  assign w_rd_addr = (r_state == S_IDLE) ? w_req_idx : w_idx_inc;
  assign w_rd_data = r_mem[w_rd_addr];

  assign w_hs     = r_rd_valid & dpi_rd_ready;
  assign w_last   = (r_rem == '0);
  assign w_mem_we = (r_state == S_WRITE) & dpi_wr_valid;

  // A request while busy, or write data outside a write burst (including the
  // request cycle itself), is flagged and otherwise ignored.
  assign w_viol = (dpi_req_valid & (r_state != S_IDLE)) |
                  (dpi_wr_valid  & (r_state != S_WRITE));

  // Array has no reset; gating on state means an async reset stops writes at once.
  always_ff @(posedge clock) begin
    if (w_mem_we) r_mem[r_idx] <= dpi_wr_bits;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_rem      <= '0;
      r_rd_valid <= 1'b0;
      r_rd_bits  <= '0;
      r_busy     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      if (w_viol) r_err <= 1'b1;

      unique case (r_state)
        S_IDLE: begin
          if (dpi_req_valid) begin
            r_idx  <= w_req_idx;
            r_rem  <= dpi_req_len;
            r_busy <= 1'b1;
            if (dpi_req_opcode) begin
              r_state <= S_WRITE;
            end else begin
              r_state    <= S_READ;
              r_rd_valid <= 1'b1;
              r_rd_bits  <= w_rd_data;
            end
          end
        end

        S_READ: begin
          if (w_hs) begin
            if (w_last) begin
              r_rd_valid <= 1'b0;
              r_state    <= S_IDLE;
              r_busy     <= 1'b0;
            end else begin
              // Next beat loaded on the same edge: no bubble between beats.
              r_rd_bits <= w_rd_data;
              r_idx     <= w_idx_inc;
              r_rem     <= r_rem - 1'b1;
            end
          end
        end

        S_WRITE: begin
          if (dpi_wr_valid) begin
            r_idx <= w_idx_inc;
            if (w_last) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_rem <= r_rem - 1'b1;
            end
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign dpi_rd_valid = r_rd_valid;
  assign dpi_rd_bits  = r_rd_bits;
  assign busy         = r_busy;
  assign err          = r_err;

endmodule

// File: tb/tb_vta_mem_dpi_responder.sv
module tb_vta_mem_dpi_responder;

  logic        clock;
  logic        reset;
  logic        dpi_req_valid;
  logic        dpi_req_opcode;
  logic [7:0]  dpi_req_len;
  logic [63:0] dpi_req_addr;
  logic        dpi_wr_valid;
  logic [63:0] dpi_wr_bits;
  logic        dpi_rd_valid;
  logic [63:0] dpi_rd_bits;
  logic        dpi_rd_ready;
  logic        busy;
  logic        err;

  vta_mem_dpi_responder #(
    .LEN_BITS(8), .ADDR_BITS(64), .DATA_BITS(64), .MEM_WORDS(4096)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .dpi_req_valid  (dpi_req_valid),
    .dpi_req_opcode (dpi_req_opcode),
    .dpi_req_len    (dpi_req_len),
    .dpi_req_addr   (dpi_req_addr),
    .dpi_wr_valid   (dpi_wr_valid),
    .dpi_wr_bits    (dpi_wr_bits),
    .dpi_rd_valid   (dpi_rd_valid),
    .dpi_rd_bits    (dpi_rd_bits),
    .dpi_rd_ready   (dpi_rd_ready),
    .busy           (busy),
    .err            (err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_chk = 0;
  int n_err = 0;
  int hs_cnt = 0;
  int hs0;

  logic [63:0] wd [4];
  logic [63:0] ev [4];

  localparam logic [63:0] A0 = 64'hA5A5_0000_0000_00A0;
  localparam logic [63:0] B0 = 64'hB5B5_0000_0000_00B0;
  localparam logic [63:0] C0 = 64'hC5C5_0000_0000_00C0;
  localparam logic [63:0] D0 = 64'hD5D5_0000_0000_00D0;

  always @(posedge clock) if (dpi_rd_valid && dpi_rd_ready) hs_cnt <= hs_cnt + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  // Async reset pulse placed mid-cycle; outputs checked while reset is high.
  task automatic pulse_reset(input string tag);
    reset = 1'b1;
    #2;
    chk({tag, "_rdv"}, dpi_rd_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_err"}, err, 0);
    reset = 1'b0;
  endtask

  task automatic wr_burst(input logic [63:0] addr, input int len, input string tag);
    dpi_req_valid = 1'b1; dpi_req_opcode = 1'b1;
    dpi_req_len = len[7:0]; dpi_req_addr = addr;
    step;
    dpi_req_valid = 1'b0;
    chk({tag, "_busy"}, busy, 1);
    for (int i = 0; i <= len; i++) begin
      dpi_wr_valid = 1'b1; dpi_wr_bits = wd[i];
      step;
    end
    dpi_wr_valid = 1'b0;
    chk({tag, "_idle"}, busy, 0);
  endtask

  task automatic rd_burst(input logic [63:0] addr, input int len, input string tag);
    dpi_req_valid = 1'b1; dpi_req_opcode = 1'b0;
    dpi_req_len = len[7:0]; dpi_req_addr = addr;
    dpi_rd_ready = 1'b1;
    step;
    dpi_req_valid = 1'b0;
    for (int i = 0; i <= len; i++) begin
      chk({tag, "_vld"}, dpi_rd_valid, 1);
      chk({tag, "_dat"}, dpi_rd_bits, ev[i]);
      step;
    end
    chk({tag, "_endv"}, dpi_rd_valid, 0);
    chk({tag, "_endb"}, busy, 0);
  endtask

  initial begin
    reset = 1'b1;
    dpi_req_valid = 1'b0; dpi_req_opcode = 1'b0; dpi_req_len = '0; dpi_req_addr = '0;
    dpi_wr_valid = 1'b0; dpi_wr_bits = '0; dpi_rd_ready = 1'b0;
    #2;
    chk("rst_rdv", dpi_rd_valid, 0);
    chk("rst_rdb", dpi_rd_bits, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    step; step;
    reset = 1'b0;
    step;

    // 1: write 4 beats at 0x40, read them back at full rate
    for (int i = 0; i < 4; i++) begin wd[i] = A0 + 64'(i); ev[i] = A0 + 64'(i); end
    wr_burst(64'h40, 3, "t1w");
    rd_burst(64'h40, 3, "t1r");
    chk("t1_err", err, 0);

    // 2: read 3 beats with ready 1,0,0,1,1
    hs0 = hs_cnt;
    dpi_req_valid = 1'b1; dpi_req_opcode = 1'b0; dpi_req_len = 8'd2; dpi_req_addr = 64'h40;
    dpi_rd_ready = 1'b1;
    step;
    dpi_req_valid = 1'b0;
    chk("t2_b0", dpi_rd_bits, A0);
    step;                        chk("t2_b1", dpi_rd_bits, A0 + 1);
    dpi_rd_ready = 1'b0; step;   chk("t2_hold1", dpi_rd_bits, A0 + 1);
                                 chk("t2_hold1v", dpi_rd_valid, 1);
    step;                        chk("t2_hold2", dpi_rd_bits, A0 + 1);
                                 chk("t2_hold2v", dpi_rd_valid, 1);
    dpi_rd_ready = 1'b1; step;   chk("t2_b2", dpi_rd_bits, A0 + 2);
    step;                        chk("t2_endv", dpi_rd_valid, 0);
                                 chk("t2_endb", busy, 0);
    chk("t2_hs", 64'(hs_cnt - hs0), 3);

    // 3: burst wrapping from the last word to word 0
    wd[0] = B0; wd[1] = B0 + 1;
    wr_burst(64'h7FF8, 1, "t3w");
    ev[0] = B0 + 1; rd_burst(64'h0, 0, "t3r0");
    ev[0] = B0;     rd_burst(64'h7FF8, 0, "t3rl");

    // 4a: stray request during a read
    for (int i = 0; i < 4; i++) ev[i] = A0 + 64'(i);
    dpi_req_valid = 1'b1; dpi_req_opcode = 1'b0; dpi_req_len = 8'd3; dpi_req_addr = 64'h40;
    dpi_rd_ready = 1'b1;
    step;
    chk("t4_b0", dpi_rd_bits, ev[0]);
    dpi_req_opcode = 1'b1; dpi_req_len = 8'd0; dpi_req_addr = 64'h0;
    step;
    dpi_req_valid = 1'b0;
    chk("t4_err", err, 1);
    chk("t4_b1", dpi_rd_bits, ev[1]);
    step; chk("t4_b2", dpi_rd_bits, ev[2]);
    step; chk("t4_b3", dpi_rd_bits, ev[3]);
    step; chk("t4_endv", dpi_rd_valid, 0);
          chk("t4_endb", busy, 0);

    // 4b: write data while idle must not touch the array
    pulse_reset("t4rst");
    step;
    dpi_wr_valid = 1'b1; dpi_wr_bits = 64'hDEAD_BEEF_DEAD_BEEF;
    step;
    dpi_wr_valid = 1'b0;
    chk("t4_err2", err, 1);
    chk("t4_busy2", busy, 0);
    ev[0] = B0 + 1; rd_burst(64'h0, 0, "t4r");

    // 5: reset in the middle of a 4-beat write
    for (int i = 0; i < 4; i++) wd[i] = C0 + 64'(i);
    wr_burst(64'h100, 3, "t5pre");
    dpi_req_valid = 1'b1; dpi_req_opcode = 1'b1; dpi_req_len = 8'd3; dpi_req_addr = 64'h100;
    step;
    dpi_req_valid = 1'b0;
    dpi_wr_valid = 1'b1; dpi_wr_bits = D0;     step;
    dpi_wr_valid = 1'b1; dpi_wr_bits = D0 + 1; step;
    dpi_wr_valid = 1'b0;
    chk("t5_busy_pre", busy, 1);
    pulse_reset("t5rst");
    step;
    ev[0] = D0; ev[1] = D0 + 1; ev[2] = C0 + 2; ev[3] = C0 + 3;
    rd_burst(64'h100, 3, "t5r");

    // wr_valid in the request cycle is a violation, not a beat
    dpi_req_valid = 1'b1; dpi_req_opcode = 1'b1; dpi_req_len = 8'd0; dpi_req_addr = 64'h200;
    dpi_wr_valid = 1'b1; dpi_wr_bits = 64'hE0;
    step;
    dpi_req_valid = 1'b0;
    dpi_wr_bits = 64'hE1;
    step;
    dpi_wr_valid = 1'b0;
    chk("t7_err", err, 1);
    chk("t7_busy", busy, 0);
    ev[0] = 64'hE1; rd_burst(64'h200, 0, "t7r");

    // 6: byte offset bits ignored
    ev[0] = A0; rd_burst(64'h47, 0, "t6r");

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
